// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer.
// USR mode encodings, FSM state type and default data width.
package usr_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_RESP
    } state_t;

endpackage

// File: rtl/usr_shift_cnt.sv
// Loadable down-counter tracking remaining shift cycles.
// Flags the last count and an empty (zero) count.
module usr_shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_dec,
    output logic             o_last,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving one universal shift register:
// load, shift/rotate N cycles, then return the final word.
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_rot,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             ser_in,
    input  logic             abort,
    output logic [1:0]       usr_sel,
    output logic             usr_s_right,
    output logic             usr_s_left,
    output logic [WIDTH-1:0] usr_p_in,
    input  logic [WIDTH-1:0] usr_p_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_rot;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_zero;
    logic             w_fill;

    assign w_accept = (r_state == S_IDLE) && cmd_valid && !abort;
    assign w_shift  = (r_state == S_SHIFT);

    usr_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rest_n (rest_n),
        .i_load (w_accept),
        .i_val  (cmd_cnt),
        .i_dec  (w_shift),
        .o_last (w_last),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= cmd_data;
                r_dir  <= cmd_dir;
                r_rot  <= cmd_rot;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort)       w_next = S_IDLE;
                else if (w_zero) w_next = S_RESP;
                else             w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Rotate recirculates the bit falling off the far end.
    assign w_fill = r_rot ? (r_dir ? usr_p_out[WIDTH-1] : usr_p_out[0])
                          : ser_in;

    always_comb begin
        cmd_ready   = 1'b0;
        usr_sel     = USR_HOLD;
        usr_s_right = 1'b0;
        usr_s_left  = 1'b0;
        usr_p_in    = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        busy        = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = !abort;
            end
            S_LOAD: begin
                usr_sel  = USR_LOAD;
                usr_p_in = r_data;
            end
            S_SHIFT: begin
                usr_sel     = r_dir ? USR_SHL : USR_SHR;
                usr_s_right = !r_dir && w_fill;
                usr_s_left  = r_dir && w_fill;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = usr_p_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Randomized self-checking bench for usr_seq_ctrl with a
// behavioural USR attached and a word-level reference model.
module tb_usr_seq_ctrl;

    localparam int W = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rest_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic          cmd_dir;
    logic          cmd_rot;
    logic [CW-1:0] cmd_cnt;
    logic          ser_in;
    logic          abort;
    logic [1:0]    usr_sel;
    logic          usr_s_right;
    logic          usr_s_left;
    logic [W-1:0]  usr_p_in;
    logic [W-1:0]  usr_p_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic [W-1:0]  usr_q;

    int n_vec;
    int n_bad;

    usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rest_n      (rest_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_dir     (cmd_dir),
        .cmd_rot     (cmd_rot),
        .cmd_cnt     (cmd_cnt),
        .ser_in      (ser_in),
        .abort       (abort),
        .usr_sel     (usr_sel),
        .usr_s_right (usr_s_right),
        .usr_s_left  (usr_s_left),
        .usr_p_in    (usr_p_in),
        .usr_p_out   (usr_p_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The shift register the sequencer drives.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) usr_q <= '0;
        else begin
            case (usr_sel)
                2'b11: usr_q <= usr_p_in;
                2'b01: usr_q <= {usr_s_right, usr_q[W-1:1]};
                2'b10: usr_q <= {usr_q[W-2:0], usr_s_left};
                default: usr_q <= usr_q;
            endcase
        end
    end
    assign usr_p_out = usr_q;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, usr_sel, 0);
        chk({tag, "_pin"}, usr_p_in, 0);
        chk({tag, "_sr"}, usr_s_right, 0);
        chk({tag, "_sl"}, usr_s_left, 0);
        chk({tag, "_rv"}, rsp_valid, 0);
        chk({tag, "_rd"}, rsp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [W-1:0] rot_word(input logic [W-1:0] d,
                                              input bit left,
                                              input int cnt);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        int k;
        k = cnt % W;
        x = {d, d};
        if (left) begin
            y = x << k;
            return y[2*W-1:W];
        end
        y = x >> k;
        return y[W-1:0];
    endfunction

    // ser < 0 randomizes ser_in; ab/rs give the shift cycle of an
    // abort or reset (0 = none); bp is the backpressure length.
    task automatic run_cmd(input logic [W-1:0] d, input bit dir,
                           input bit rot, input int cnt, input int ser,
                           input int ab, input int rs, input int bp);
        logic [W-1:0] e;
        logic [W-1:0] want;
        bit f;
        bit sb;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_rot   = rot;
        cmd_cnt   = cnt[CW-1:0];
        abort     = 1'b0;
        rsp_ready = 1'b0;
        #1 chk("acc_rdy", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = W'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_cnt   = CW'($urandom);
        #1;
        chk("ld_sel", usr_sel, 3);
        chk("ld_pin", usr_p_in, d);
        chk("ld_rdy", cmd_ready, 0);
        chk("ld_busy", busy, 1);
        e = d;
        for (int k = 1; k <= cnt; k++) begin
            @(negedge clk);
            sb = (ser < 0) ? 1'($urandom_range(0, 1)) : ser[0];
            ser_in = sb;
            abort = (k == ab);
            if (k == rs) begin
                rest_n = 1'b0;
                #1 chk_reset_vals("rst");
                @(negedge clk);
                rest_n = 1'b1;
                #1 chk("rst_rdy", cmd_ready, 1);
                return;
            end
            #1;
            f = rot ? (dir ? e[W-1] : e[0]) : sb;
            chk("sh_sel", usr_sel, dir ? 2 : 1);
            chk("sh_sr", usr_s_right, dir ? 1'b0 : f);
            chk("sh_sl", usr_s_left, dir ? f : 1'b0);
            chk("sh_rv", rsp_valid, 0);
            chk("sh_rdy", cmd_ready, 0);
            e = dir ? {e[W-2:0], f} : {f, e[W-1:1]};
            if (k == ab) begin
                @(negedge clk);
                abort = 1'b0;
                #1;
                chk("ab_busy", busy, 0);
                chk("ab_sel", usr_sel, 0);
                chk("ab_rv", rsp_valid, 0);
                chk("ab_part", usr_p_out, e);
                return;
            end
        end
        want = rot ? rot_word(d, dir, cnt) : e;
        for (int b = 0; b <= bp; b++) begin
            @(negedge clk);
            rsp_ready = (b == bp);
            abort = 1'($urandom_range(0, 1));
            #1;
            chk("rs_rv", rsp_valid, 1);
            chk("rs_data", rsp_data, want);
            chk("rs_sel", usr_sel, 0);
            chk("rs_rdy", cmd_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        abort = 1'b0;
        #1;
        chk("id_busy", busy, 0);
        chk("id_rdy", cmd_ready, 1);
        chk("id_rv", rsp_valid, 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rest_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = '0;
        cmd_dir = 1'b0;
        cmd_rot = 1'b0;
        cmd_cnt = '0;
        ser_in = 1'b0;
        abort = 1'b0;
        rsp_ready = 1'b0;
        #3 chk_reset_vals("por");
        @(negedge clk);
        rest_n = 1'b1;
        #1 chk("por_rdy", cmd_ready, 1);

        run_cmd(4'b1010, 1'b0, 1'b0, 1, 0, 0, 0, 0);
        run_cmd(4'b1010, 1'b1, 1'b0, 2, 1, 0, 0, 0);
        run_cmd(4'b1010, 1'b0, 1'b1, 1, -1, 0, 0, 0);
        run_cmd(4'b1010, 1'b0, 1'b1, 4, -1, 0, 0, 0);
        run_cmd(4'b1010, 1'b0, 1'b1, 7, -1, 0, 0, 0);
        run_cmd(4'b0110, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        run_cmd(4'b1100, 1'b1, 1'b0, 3, -1, 0, 0, 3);
        run_cmd(4'b0011, 1'b0, 1'b0, 5, -1, 2, 0, 0);
        run_cmd(4'b1001, 1'b1, 1'b1, 6, -1, 0, 3, 0);

        @(negedge clk);
        cmd_valid = 1'b1;
        abort = 1'b1;
        #1 chk("iab_rdy", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b0;
        #1 chk("iab_busy", busy, 0);

        for (int i = 0; i < 60; i++) begin
            int c;
            int a;
            c = $urandom_range(0, 7);
            a = ($urandom_range(0, 5) == 0 && c > 0) ? $urandom_range(1, c) : 0;
            run_cmd(W'($urandom), 1'($urandom), 1'($urandom), c, -1,
                    a, 0, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
